regwb_arbiter: RTL
==================

REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of entries in each per-requester queue (power of two, at least 2).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 a_valid / a_ready  input / output  1 / 1  handshake for requester A (ALU writeback).
REQ-005 a_reg / a_data  input / input  5 / 32  destination register and write value for requester A.
REQ-006 b_valid / b_ready  input / output  1 / 1  handshake for requester B (load writeback).
REQ-007 b_reg / b_data  input / input  5 / 32  destination register and write value for requester B.
REQ-008 we / wreg / wdata  output / output / output  1 / 5 / 32  registered single write port driving the register file.
REQ-009 chk_reg / chk_hit  input / output  5 / 1  hazard query: pending write to chk_reg.

Function
REQ-010 A transfer SHALL occur on a clk edge where x_valid=1 and x_ready=1; the entry SHALL be pushed into queue x.
REQ-011 x_ready SHALL equal "queue x not full", with no dependence on the same-cycle pop; a full queue SHALL refuse input even while it is being popped.
REQ-012 Each cycle, at most one queue head SHALL be popped: only A non-empty -> A; only B non-empty -> B; both non-empty -> the requester not granted last (round-robin); both empty -> no pop.
REQ-013 The last-grant pointer SHALL update only on a pop.
REQ-014 On a pop, at the same edge, we SHALL be loaded with 1 if the head reg is nonzero and 0 otherwise; wreg and wdata SHALL be loaded with the head fields.
REQ-015 With no pop, we SHALL be loaded with 0 and wreg/wdata SHALL hold their values.
REQ-016 Latency SHALL be exactly 1 edge from push (edge N) to we=1 (after edge N+1) when the queue is empty and not losing arbitration; the register file write then lands at edge N+2.
REQ-017 Entries from one requester SHALL reach the write port in acceptance order; no ordering is guaranteed between A and B.
REQ-018 Writes to register 0 SHALL be consumed (popped, arbitration slot used) but never assert we.
REQ-019 A push into an empty queue SHALL NOT be popped on the same edge; the queue becomes visible to the arbiter the next cycle.
REQ-020 chk_hit SHALL be combinational and SHALL be 1 iff chk_reg != 0 and chk_reg matches either of the following:
- the reg field of any valid entry in either queue;
- wreg while we=1.
REQ-021 Queue pointers SHALL wrap modulo DEPTH; occupancy counters SHALL be log2(DEPTH)+1 bits wide so full and empty are unambiguous.

Reset
REQ-022 While rst=1, asynchronously:
- both queues empty;
- a_ready=b_ready=1;
- we=0, wreg=0, wdata=0;
- last-grant=B, so A wins the first tie.
REQ-023 An assertion of rst mid-operation SHALL discard all queued entries; no write SHALL issue after reset release until a new transfer completes.

Structure
REQ-024 Shared package SHALL hold REG_AW=5, DATA_W=32 and the grant-select encoding (GRANT_A, GRANT_B).
REQ-025 One sub-module, wb_fifo (DEPTH x 37-bit synchronous FIFO with full/empty and per-entry reg tap for hazard compare), SHALL be instantiated twice.

Verification
REQ-026 Single A push reg=8, data=0x00000001 at edge 1 -> we=1, wreg=8, wdata=0x1 after edge 2; we=0 after edge 3.
REQ-027 A and B pushed on the same edge (A reg=9 data=0x2, B reg=13 data=0x20), repeated for 3 cycles -> write sequence A,B,A,B,A,B with no gaps after the first.
REQ-028 B held with valid=1 for 4 cycles while the arbiter is saturated by A with DEPTH=2 -> b_ready=0 after 2 accepts; B entries drain in order.
REQ-029 Push A reg=0 data=0xFFFFFFFF -> queue pops, we stays 0; chk_reg=0 -> chk_hit=0.
REQ-030 Queue A holds reg=21, chk_reg=21 -> chk_hit=1 until the cycle after we=1 for reg 21 is deasserted; chk_reg=22 -> chk_hit=0 throughout.
REQ-031 rst pulse while both queues hold 2 entries -> we=0 immediately, both ready=1, no writes issued until a new push.

Source files
------------

// File: rtl/regwb_arbiter_pkg.sv
// Shared widths, grant encoding and the queue entry layout
// for the register-file writeback arbiter.
package regwb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regwb_arbiter_wb_fifo.sv
// Small circular writeback queue with a per-slot register tap
// so the owner can compare pending destinations against a query.
module wb_fifo
  import regwb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_entry_t                     din,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic                          full,
  output logic                          empty,
  output logic [DEPTH-1:0][REG_AW-1:0]  tap_reg,
  output logic [DEPTH-1:0]              tap_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt == FULL_CNT;
  assign empty   = cnt == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [AW-1:0] off;
    assign off          = AW'(i) - rptr;
    assign tap_reg[i]   = mem[i].rd;
    assign tap_valid[i] = {1'b0, off} < cnt;
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Round-robin merge of ALU and load writebacks onto one
// registered register-file write port, with a pending-write query.
module regwb_arbiter
  import regwb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [REG_AW-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              we,
  output logic [REG_AW-1:0] wreg,
  output logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] chk_reg,
  output logic              chk_hit
);

  wb_entry_t                   a_head;
  wb_entry_t                   b_head;
  wb_entry_t                   win;
  logic                        a_full;
  logic                        a_empty;
  logic                        b_full;
  logic                        b_empty;
  logic [DEPTH-1:0][REG_AW-1:0] a_treg;
  logic [DEPTH-1:0][REG_AW-1:0] b_treg;
  logic [DEPTH-1:0]            a_tv;
  logic [DEPTH-1:0]            b_tv;
  logic                        pop_a;
  logic                        pop_b;
  logic                        last;
  logic                        hit;

  assign a_ready = !a_full;
  assign b_ready = !b_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_valid),
    .din       ({a_reg, a_data}),
    .pop       (pop_a),
    .head      (a_head),
    .full      (a_full),
    .empty     (a_empty),
    .tap_reg   (a_treg),
    .tap_valid (a_tv)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_valid),
    .din       ({b_reg, b_data}),
    .pop       (pop_b),
    .head      (b_head),
    .full      (b_full),
    .empty     (b_empty),
    .tap_reg   (b_treg),
    .tap_valid (b_tv)
  );

  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    unique case (1'b1)
      !a_empty && (b_empty || last == GRANT_B): pop_a = 1'b1;
      !b_empty && (a_empty || last == GRANT_A): pop_b = 1'b1;
      default: ;
    endcase
  end

  assign win = pop_a ? a_head : b_head;

  // Register 0 still consumes its slot but never reaches the file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
      last  <= GRANT_B;
    end else if (pop_a || pop_b) begin
      we    <= win.rd != '0;
      wreg  <= win.rd;
      wdata <= win.data;
      last  <= pop_a ? GRANT_A : GRANT_B;
    end else begin
      we <= 1'b0;
    end
  end

  always_comb begin
    hit = we && (wreg == chk_reg);
    for (int i = 0; i < DEPTH; i++) begin
      if (a_tv[i] && a_treg[i] == chk_reg) hit = 1'b1;
      if (b_tv[i] && b_treg[i] == chk_reg) hit = 1'b1;
    end
  end

  assign chk_hit = hit && (chk_reg != '0);

endmodule
